bcd_timer: RTL and testbench
============================

BCD_TIMER -- requirements
Module: bcd_timer

Interface
REQ-001 Parameter: TICKS_PER_SEC, default 50_000_000, number of clk cycles per counted second; legal values are 2 or more.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 key_valid  input  1  one-cycle strobe; key_digit is valid in that cycle.
REQ-005 key_digit  input  4  BCD digit entered on the keypad, legal values 0-9.
REQ-006 start  input  1  one-cycle strobe that starts or resumes the countdown.
REQ-007 stop  input  1  one-cycle strobe that pauses the countdown.
REQ-008 clear  input  1  one-cycle strobe that zeroes the time and returns to SET.
REQ-009 sec_ones  output  4  BCD units-of-seconds digit; feeds the 7-segment decoder.
REQ-010 sec_tens  output  4  BCD tens-of-seconds digit; feeds the 7-segment decoder.
REQ-011 mins  output  4  BCD minutes digit; feeds the 7-segment decoder.
REQ-012 running  output  1  high while in state RUN.
REQ-013 done  output  1  one-cycle pulse when the countdown reaches 0:00.

Function
REQ-014 States SHALL be SET, RUN and PAUSE, with SET as the reset state.
REQ-015 All outputs SHALL be registered; sec_ones, sec_tens and mins are always the current stored time.
REQ-016 Control priority in any cycle SHALL be clear > stop > start > key_valid; lower-priority strobes in that cycle are ignored.
REQ-017 clear in any state: digits become 0, state becomes SET, prescaler becomes 0, and done stays 0.
REQ-018 Keypad entry SHALL apply only in SET: on key_valid with key_digit ≤ 9, do mins←sec_tens, sec_tens←sec_ones, sec_ones←key_digit, taking effect the next cycle.
REQ-019 key_valid with key_digit > 9, or key_valid in RUN or PAUSE, SHALL be ignored.
REQ-020 Digit entry does not range-check sec_tens; values 6-9 are accepted and count down as given.
REQ-021 start in SET or PAUSE with a time other than 0:00: go to RUN and set the prescaler to 0.
REQ-022 start when the time is 0:00: no effect.
REQ-023 start while already in RUN: no effect.
REQ-024 Prescaler in RUN: counts 0 to TICKS_PER_SEC-1 and wraps to 0.
REQ-025 On each wrap, the time SHALL decrement by one second, so the first decrement occurs TICKS_PER_SEC cycles after the start edge.
REQ-026 Prescaler outside RUN: held.
REQ-027 Decrement rules, applied as one borrow chain (units, then tens, then minutes):
  - sec_ones: if sec_ones > 0, sec_ones−1.
  - sec_ones = 0: sec_ones←9 and borrow from sec_tens.
  - sec_tens borrow: if sec_tens > 0, sec_tens−1; otherwise sec_tens←5 and mins−1.
REQ-028 A decrement that produces 0:00 SHALL, in the same edge, move the state to SET, drop running, and assert done for exactly one cycle.
REQ-029 stop in RUN: go to PAUSE; the time and prescaler are frozen, including when a prescaler wrap falls in the same cycle (no decrement occurs).
REQ-030 stop in PAUSE: go to SET, keeping the time so that it can be re-edited.
REQ-031 stop in SET: no effect.
REQ-032 running SHALL equal (state == RUN) at every cycle.

Reset
REQ-033 On reset assertion, immediately and regardless of clk: digits 0, prescaler 0, state SET, running 0, done 0.
REQ-034 Reset mid-countdown SHALL abort the countdown with no done pulse.
REQ-035 After reset deasserts, operation resumes on the next clk rising edge.

Verification
REQ-036 (TICKS_PER_SEC=4 for all scenarios.) Key in 1,3,0 in SET -> mins=1, sec_tens=3, sec_ones=0; key_digit=12 -> value unchanged.
REQ-037 Time 1:00, start -> running=1 the next cycle; 4 cycles later 0:59; 4 cycles after that 0:58.
REQ-038 Time 0:02, start -> 0:01 after 4 cycles, then 0:00 with done=1 for one cycle, running=0, state SET.
REQ-039 RUN at 0:45, stop on the wrap cycle -> time stays 0:45, PAUSE. Then start -> next decrement to 0:44 exactly 4 cycles after the start.
REQ-040 Time 0:00, start -> state stays SET, running=0, done=0; clear together with start in RUN -> 0:00, SET.
REQ-041 Assert reset asynchronously mid-RUN at 2:17 -> all outputs 0 before the next clk edge; no done pulse.

Source files
------------

// File: rtl/bcd_timer.sv
// rtl/bcd_timer.sv - keypad-set m:ss BCD countdown timer with SET/RUN/PAUSE control
// All outputs are registers; next values are computed in one combinational block.
module bcd_timer #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] mins,
  output logic       running,
  output logic       done
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {SET, RUN, PAUSE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    ones_q, ones_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    mins_q, mins_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          running_q, done_q, done_d;
  logic          time_zero, last_second;

  assign time_zero   = (mins_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);
  assign last_second = (mins_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= SET;
      ones_q    <= 4'd0;
      tens_q    <= 4'd0;
      mins_q    <= 4'd0;
      presc_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ones_q    <= ones_d;
      tens_q    <= tens_d;
      mins_q    <= mins_d;
      presc_q   <= presc_d;
      running_q <= (state_d == RUN);
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    mins_d  = mins_q;
    presc_d = presc_q;
    done_d  = 1'b0;

    if (clear) begin
      state_d = SET;
      ones_d  = 4'd0;
      tens_d  = 4'd0;
      mins_d  = 4'd0;
      presc_d = '0;
    end else begin
      // A stop landing on the wrap cycle freezes the time without decrementing.
      if (state_q == RUN && !stop) begin
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          if (ones_q != 4'd0) begin
            ones_d = ones_q - 4'd1;
          end else begin
            ones_d = 4'd9;
            if (tens_q != 4'd0) begin
              tens_d = tens_q - 4'd1;
            end else begin
              tens_d = 4'd5;
              mins_d = mins_q - 4'd1;
            end
          end
          if (last_second) begin
            state_d = SET;
            done_d  = 1'b1;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end

      if (stop) begin
        if (state_q == RUN)        state_d = PAUSE;
        else if (state_q == PAUSE) state_d = SET;
      end else if (start) begin
        if (state_q != RUN && !time_zero) begin
          state_d = RUN;
          presc_d = '0;
        end
      end else if (key_valid && state_q == SET && key_digit <= 4'd9) begin
        mins_d = tens_q;
        tens_d = ones_q;
        ones_d = key_digit;
      end
    end
  end

  assign sec_ones = ones_q;
  assign sec_tens = tens_q;
  assign mins     = mins_q;
  assign running  = running_q;
  assign done     = done_q;

endmodule

// File: tb/tb_bcd_timer.sv
// tb/tb_bcd_timer.sv - directed and randomized checks of bcd_timer against a seconds-based model
module tb_bcd_timer;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] sec_ones, sec_tens, mins;
  logic       running, done;

  int n_pass = 0;
  int n_total = 0;

  // Model: minutes digit plus a two-digit seconds field 0..99 (tens may exceed 5).
  int m_state = 0;  // 0 SET, 1 RUN, 2 PAUSE
  int m_mins = 0;
  int m_secs = 0;
  int m_presc = 0;
  int m_done = 0;

  logic [13:0] obs, exp_v;
  assign obs = {mins, sec_tens, sec_ones, running, done};

  always #5 clk = ~clk;

  bcd_timer #(.TICKS_PER_SEC(T)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_digit(key_digit),
    .start(start), .stop(stop), .clear(clear),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .mins(mins),
    .running(running), .done(done)
  );

  task automatic model_reset();
    m_state = 0; m_mins = 0; m_secs = 0; m_presc = 0; m_done = 0;
  endtask

  task automatic model_step(input int kv, input int kd, input int st, input int sp, input int cl);
    int old_state;
    old_state = m_state;
    m_done = 0;
    if (cl != 0) begin
      m_state = 0; m_mins = 0; m_secs = 0; m_presc = 0;
    end else begin
      if (old_state == 1 && sp == 0) begin
        if (m_presc == T - 1) begin
          m_presc = 0;
          if (m_secs > 0) m_secs = m_secs - 1;
          else begin m_secs = 59; m_mins = m_mins - 1; end
          if (m_mins == 0 && m_secs == 0) begin m_state = 0; m_done = 1; end
        end else m_presc = m_presc + 1;
      end
      if (sp != 0) begin
        if (old_state == 1) m_state = 2;
        else if (old_state == 2) m_state = 0;
      end else if (st != 0) begin
        if (old_state != 1 && (m_mins * 100 + m_secs) != 0) begin m_state = 1; m_presc = 0; end
      end else if (kv != 0 && old_state == 0 && kd <= 9) begin
        m_mins = m_secs / 10;
        m_secs = (m_secs % 10) * 10 + kd;
      end
    end
  endtask

  function automatic logic [13:0] model_vec();
    return {4'(m_mins), 4'(m_secs / 10), 4'(m_secs % 10), (m_state == 1), (m_done != 0)};
  endfunction

  // One clock: apply strobes, advance model at the edge, then release strobes.
  task automatic drive(input logic kv, input logic [3:0] kd, input logic st, input logic sp, input logic cl);
    key_valid = kv; key_digit = kd; start = st; stop = sp; clear = cl;
    @(posedge clk);
    model_step(int'(kv), int'(kd), int'(st), int'(sp), int'(cl));
    #1;
    key_valid = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic key(input logic [3:0] d);
    drive(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    #23;
    n_total++;
    if (obs !== 14'd0) $display("FAIL reset_hold: got %h expected %h", obs, 14'd0); else n_pass++;
    reset = 1'b0;
    model_reset();
    idle(2);
    n_total++;
    if (obs !== 14'd0) $display("FAIL reset_idle: got %h expected %h", obs, 14'd0); else n_pass++;
  endtask

  task automatic test_keypad();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    key(4'd1); key(4'd3); key(4'd0);
    exp_v = {4'd1, 4'd3, 4'd0, 1'b0, 1'b0};
    n_total++;
    if (obs !== exp_v) $display("FAIL keypad_130: got %h expected %h", obs, exp_v); else n_pass++;
    key(4'd12);
    n_total++;
    if (obs !== exp_v) $display("FAIL keypad_illegal: got %h expected %h", obs, exp_v); else n_pass++;
  endtask

  task automatic test_countdown();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    key(4'd1); key(4'd0); key(4'd0);
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    exp_v = {4'd1, 4'd0, 4'd0, 1'b1, 1'b0};
    n_total++;
    if (obs !== exp_v) $display("FAIL cd_running: got %h expected %h", obs, exp_v); else n_pass++;
    idle(3);
    n_total++;
    if (obs !== exp_v) $display("FAIL cd_before_tick: got %h expected %h", obs, exp_v); else n_pass++;
    idle(1);
    exp_v = {4'd0, 4'd5, 4'd9, 1'b1, 1'b0};
    n_total++;
    if (obs !== exp_v) $display("FAIL cd_059: got %h expected %h", obs, exp_v); else n_pass++;
    key(4'd7);  // ignored while running
    idle(3);
    exp_v = {4'd0, 4'd5, 4'd8, 1'b1, 1'b0};
    n_total++;
    if (obs !== exp_v) $display("FAIL cd_058: got %h expected %h", obs, exp_v); else n_pass++;
  endtask

  task automatic test_done();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    key(4'd2);
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle(4);
    exp_v = {4'd0, 4'd0, 4'd1, 1'b1, 1'b0};
    n_total++;
    if (obs !== exp_v) $display("FAIL done_001: got %h expected %h", obs, exp_v); else n_pass++;
    idle(4);
    exp_v = {4'd0, 4'd0, 4'd0, 1'b0, 1'b1};
    n_total++;
    if (obs !== exp_v) $display("FAIL done_pulse: got %h expected %h", obs, exp_v); else n_pass++;
    idle(1);
    exp_v = 14'd0;
    n_total++;
    if (obs !== exp_v) $display("FAIL done_one_cycle: got %h expected %h", obs, exp_v); else n_pass++;
    key(4'd3);  // back in SET, so keypad works again
    exp_v = {4'd0, 4'd0, 4'd3, 1'b0, 1'b0};
    n_total++;
    if (obs !== exp_v) $display("FAIL done_set_state: got %h expected %h", obs, exp_v); else n_pass++;
  endtask

  task automatic test_stop_wrap();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    key(4'd4); key(4'd5);
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle(3);
    drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    exp_v = {4'd0, 4'd4, 4'd5, 1'b0, 1'b0};
    n_total++;
    if (obs !== exp_v) $display("FAIL stop_on_wrap: got %h expected %h", obs, exp_v); else n_pass++;
    idle(6);
    n_total++;
    if (obs !== exp_v) $display("FAIL pause_frozen: got %h expected %h", obs, exp_v); else n_pass++;
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle(3);
    exp_v = {4'd0, 4'd4, 4'd5, 1'b1, 1'b0};
    n_total++;
    if (obs !== exp_v) $display("FAIL resume_pre: got %h expected %h", obs, exp_v); else n_pass++;
    idle(1);
    exp_v = {4'd0, 4'd4, 4'd4, 1'b1, 1'b0};
    n_total++;
    if (obs !== exp_v) $display("FAIL resume_044: got %h expected %h", obs, exp_v); else n_pass++;
    drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    key(4'd9);  // second stop returned to SET, time kept for editing
    exp_v = {4'd4, 4'd4, 4'd9, 1'b0, 1'b0};
    n_total++;
    if (obs !== exp_v) $display("FAIL pause_to_set_edit: got %h expected %h", obs, exp_v); else n_pass++;
  endtask

  task automatic test_zero_start_clear();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle(1);
    n_total++;
    if (obs !== 14'd0) $display("FAIL start_at_zero: got %h expected %h", obs, 14'd0); else n_pass++;
    key(4'd5);
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle(1);
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    n_total++;
    if (obs !== 14'd0) $display("FAIL clear_with_start: got %h expected %h", obs, 14'd0); else n_pass++;
    idle(5);
    n_total++;
    if (obs !== 14'd0) $display("FAIL clear_stays_set: got %h expected %h", obs, 14'd0); else n_pass++;
  endtask

  task automatic test_async_reset();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    key(4'd2); key(4'd1); key(4'd7);
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle(2);
    exp_v = {4'd2, 4'd1, 4'd7, 1'b1, 1'b0};
    n_total++;
    if (obs !== exp_v) $display("FAIL areset_pre: got %h expected %h", obs, exp_v); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_total++;
    if (obs !== 14'd0) $display("FAIL areset_immediate: got %h expected %h", obs, 14'd0); else n_pass++;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    idle(8);
    n_total++;
    if (obs !== 14'd0) $display("FAIL areset_no_done: got %h expected %h", obs, 14'd0); else n_pass++;
  endtask

  task automatic test_random();
    logic kv, st, sp, cl;
    logic [3:0] kd;
    int errs;
    errs = 0;
    for (int i = 0; i < 1500; i++) begin
      kv = ($urandom_range(0, 99) < 35);
      kd = 4'($urandom_range(0, 11));
      st = ($urandom_range(0, 99) < 8);
      sp = ($urandom_range(0, 99) < 3);
      cl = ($urandom_range(0, 299) < 2);
      drive(kv, kd, st, sp, cl);
      exp_v = model_vec();
      n_total++;
      if (obs !== exp_v) begin
        errs++;
        if (errs < 10) $display("FAIL random_cycle_%0d: got %h expected %h", i, obs, exp_v);
      end else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_keypad();
    test_countdown();
    test_done();
    test_stop_wrap();
    test_zero_start_clear();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
